// File: rtl/instr_fetch.sv
// instr_fetch: 16x8 program RAM, registered fetch (1-cycle latency), run/step/halt sequencer, one commit per TICK_DIV cycles.
// Loads accepted only in IDLE/HALT via load_ready and never queued; define INSTR_FETCH_STEP_EN to add the single-step state.
module instr_fetch #(
    parameter int TICK_DIV         = 4,
    parameter bit HALT_ON_SELF_JMP = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] ip,
    input  logic       run,
    input  logic       step,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [3:0] load_addr,
    input  logic [7:0] load_data,
    output logic [3:0] opecode,
    output logic [3:0] imm,
    output logic       commit,
    output logic       running,
    output logic       halted
);

    localparam int            CW        = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [3:0]    ADD_A_IMM = 4'h0;
    localparam logic [3:0]    JMP_IMM   = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
`ifdef INSTR_FETCH_STEP_EN
        , S_STEP
`endif
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_tick;
    logic [CW-1:0] w_tick_nxt;
    logic [7:0]    r_mem [16];
    logic [3:0]    r_opecode;
    logic [3:0]    r_imm;
    logic [3:0]    r_ip_cap;
    logic          r_cap_ok;
    logic          w_wr;
    logic          w_fvalid;
    logic          w_tick_last;
    logic          w_self_jmp;
    logic          w_commit;

`ifndef INSTR_FETCH_STEP_EN
    logic w_step_unused;
    assign w_step_unused = step;
`endif

    assign load_ready  = (r_state == S_IDLE) || (r_state == S_HALT);
    assign w_wr        = load_valid && load_ready;
    // Fetched word is trustworthy only if it was read from the current ip and no write raced it.
    assign w_fvalid    = r_cap_ok && (r_ip_cap == ip);
    assign w_tick_last = (r_tick == TICK_LAST);
    assign w_self_jmp  = HALT_ON_SELF_JMP && (r_opecode == JMP_IMM) && (r_imm == ip);

    assign opecode = r_opecode;
    assign imm     = r_imm;
    assign commit  = w_commit;
    assign running = (r_state == S_RUN);
    assign halted  = (r_state == S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_wr) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opecode <= ADD_A_IMM;
            r_imm     <= 4'h0;
            r_ip_cap  <= 4'h0;
            r_cap_ok  <= 1'b0;
        end else begin
            {r_opecode, r_imm} <= r_mem[ip];
            r_ip_cap           <= ip;
            r_cap_ok           <= !(w_wr && (load_addr == ip));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tick_nxt = '0;
                if (run) begin
                    w_state_nxt = S_RUN;
                end
`ifdef INSTR_FETCH_STEP_EN
                else if (step) begin
                    w_state_nxt = S_STEP;
                end
`endif
            end
            S_RUN: begin
                if (!run) begin
                    w_state_nxt = S_IDLE;
                end else if (!w_tick_last) begin
                    w_tick_nxt = r_tick + 1'b1;
                end else if (w_fvalid) begin
                    // Counter holds at its last value while the fetch catches up.
                    w_commit   = 1'b1;
                    w_tick_nxt = '0;
                    if (w_self_jmp) begin
                        w_state_nxt = S_HALT;
                    end
                end
            end
            S_HALT: begin
                if (!run) begin
                    w_state_nxt = S_IDLE;
                end
            end
`ifdef INSTR_FETCH_STEP_EN
            S_STEP: begin
                if (w_fvalid) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch with a queue-based register-stage model.
module tb_instr_fetch;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] ip = 4'h0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       load_valid = 1'b0;
    logic [3:0] load_addr = 4'h0;
    logic [7:0] load_data = 8'h00;
    logic       load_ready;
    logic [3:0] opecode;
    logic [3:0] imm;
    logic       commit;
    logic       running;
    logic       halted;

    instr_fetch #(.TICK_DIV(TICK_DIV), .HALT_ON_SELF_JMP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ip(ip), .run(run), .step(step),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_addr(load_addr), .load_data(load_data),
        .opecode(opecode), .imm(imm), .commit(commit),
        .running(running), .halted(halted)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] model_mem [16];
    logic [7:0] exp_q [$];
    int         cyc = 0;
    int         n_commit = 0;
    int         last_commit_cyc = -100;
    int         run_start_cyc = 0;
    int         exp_gap = TICK_DIV;
    bit         gap_chk_en = 1'b1;
    bit         model_en = 1'b0;
    bit         push_en = 1'b1;
    bit         halt_pred = 1'b0;
    int         stale_dly = 0;
    int         pend_cnt = 0;
    logic [3:0] pend_ip = 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every commit and checks spacing.
    initial begin : monitor
        bit         prev_commit;
        logic [7:0] e;
        prev_commit = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (commit) begin
                n_commit++;
                check("commit_back_to_back", 32'(prev_commit), 32'd0);
                check("commit_scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("commit_word", 32'({opecode, imm}), 32'(e));
                end
                if (gap_chk_en) begin
                    if (last_commit_cyc >= run_start_cyc)
                        check("commit_gap", 32'(cyc - last_commit_cyc), 32'(exp_gap));
                    else
                        check("first_commit_latency", 32'(cyc - run_start_cyc), 32'(TICK_DIV));
                end
                last_commit_cyc = cyc;
            end
            prev_commit = commit;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic apply_ip(input logic [3:0] v);
        ip = v;
        if (push_en) exp_q.push_back(model_mem[v]);
    endtask

    // One clock cycle; the register-stage model reacts to commits seen in that cycle.
    task automatic tick();
        bit c;
        @(negedge clk);
        c = commit;
        @(posedge clk);
        #1;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) apply_ip(pend_ip);
        end
        if (c && model_en) begin
            logic [7:0] w;
            w = model_mem[ip];
            if (w[7:4] == 4'hF && w[3:0] == ip) begin
                halt_pred = 1'b1;
            end else begin
                pend_ip = (w[7:4] == 4'hF) ? w[3:0] : ip + 4'd1;
                if (stale_dly == 0) apply_ip(pend_ip);
                else pend_cnt = stale_dly;
            end
        end
    endtask

    task automatic load_word(input logic [3:0] a, input logic [7:0] d);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        check("load_ready_idle", 32'(load_ready), 32'd1);
        model_mem[a] = d;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic start_run();
        run = 1'b1;
        run_start_cyc = cyc + 1;
        halt_pred = 1'b0;
    endtask

    task automatic finish_run();
        run = 1'b0;
        repeat (6) tick();
        pend_cnt = 0;
        exp_q.delete();
        check("idle_running", 32'(running), 32'd0);
        check("idle_halted", 32'(halted), 32'd0);
        check("idle_load_ready", 32'(load_ready), 32'd1);
    endtask

    initial begin : main
        int  n0;
        bit  found;
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_opecode", 32'(opecode), 32'd0);
        check("rst_imm", 32'(imm), 32'd0);
        check("rst_commit", 32'(commit), 32'd0);
        check("rst_load_ready", 32'(load_ready), 32'd1);
        check("rst_running", 32'(running), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed: ADD then self-jump halts
        model_en = 1'b1;
        load_word(4'd0, 8'h33);
        load_word(4'd1, 8'hF1);
        apply_ip(4'd0);
        n0 = n_commit;
        start_run();
        repeat (20) tick();
        check("directed_commit_count", 32'(n_commit - n0), 32'd2);
        check("directed_halted", 32'(halted), 32'd1);
        check("directed_running", 32'(running), 32'd0);
        check("halt_load_ready", 32'(load_ready), 32'd1);
        check("directed_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        finish_run();

        // Stale ip from the register stage, with ignored loads during RUN
        for (int a = 0; a < 16; a++)
            load_word(4'(a), {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))});
        stale_dly = 3;
        exp_gap = (stale_dly + 2 > TICK_DIV) ? stale_dly + 2 : TICK_DIV;
        apply_ip(4'd0);
        n0 = n_commit;
        start_run();
        for (int i = 0; i < 60; i++) begin
            if (i >= 2) begin
                load_valid = 1'($urandom_range(0, 1));
                load_addr  = 4'($urandom_range(0, 15));
                load_data  = 8'($urandom_range(0, 255));
                check("load_ready_in_run", 32'(load_ready), 32'd0);
            end
            tick();
        end
        load_valid = 1'b0;
        check("stale_progress", 32'(n_commit - n0 >= 10), 32'd1);
        finish_run();

        // Random programs, random stall depth, write to ip's address just before RUN
        for (int ph = 0; ph < 4; ph++) begin
            logic [3:0] ip0;
            ip0 = 4'($urandom_range(0, 15));
            ip = ip0;
            for (int a = 0; a < 16; a++) load_word(4'(a), 8'($urandom_range(0, 255)));
            load_word(ip0, 8'($urandom_range(0, 255)));
            stale_dly = $urandom_range(0, 3);
            exp_gap = (stale_dly + 2 > TICK_DIV) ? stale_dly + 2 : TICK_DIV;
            exp_q.push_back(model_mem[ip0]);
            n0 = n_commit;
            start_run();
            repeat (40) tick();
            check("rand_running", 32'(running), 32'(!halt_pred));
            check("rand_halted", 32'(halted), 32'(halt_pred));
            if (!halt_pred) check("rand_progress", 32'(n_commit - n0 >= 5), 32'd1);
            finish_run();
        end

        // Single step
        model_en = 1'b0;
        gap_chk_en = 1'b0;
        stale_dly = 0;
        ip = 4'd2;
        load_word(4'd2, 8'h5A);
`ifdef INSTR_FETCH_STEP_EN
        exp_q.push_back(8'h5A);
        n0 = n_commit;
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (8) tick();
        check("step_commit_count", 32'(n_commit - n0), 32'd1);
        check("step_back_idle", 32'(load_ready), 32'd1);
        check("step_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        load_valid = 1'b1;
        load_addr  = 4'd2;
        load_data  = 8'h6C;
        model_mem[2] = 8'h6C;
        exp_q.push_back(8'h6C);
        check("load_ready_idle", 32'(load_ready), 32'd1);
        n0 = n_commit;
        step = 1'b1;
        tick();
        step = 1'b0;
        load_valid = 1'b0;
        repeat (8) tick();
        check("step_after_write_count", 32'(n_commit - n0), 32'd1);
        check("step_after_write_empty", 32'(exp_q.size()), 32'd0);

        step = 1'b1;
        run = 1'b1;
        tick();
        step = 1'b0;
        check("step_run_both_running", 32'(running), 32'd1);
        run = 1'b0;
        repeat (3) tick();
        check("step_run_both_idle", 32'(running), 32'd0);
`else
        n0 = n_commit;
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (8) tick();
        check("step_ignored_count", 32'(n_commit - n0), 32'd0);
        check("step_ignored_running", 32'(running), 32'd0);
`endif

        // Reset during a commit cycle, then all-zero memory run across the ip wrap
        model_en = 1'b1;
        gap_chk_en = 1'b1;
        exp_gap = TICK_DIV;
        apply_ip(4'd0);
        start_run();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (commit) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("reset_found_commit", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_commit", 32'(commit), 32'd0);
        check("midrst_running", 32'(running), 32'd0);
        check("midrst_halted", 32'(halted), 32'd0);
        check("midrst_load_ready", 32'(load_ready), 32'd1);
        check("midrst_opecode", 32'(opecode), 32'd0);
        check("midrst_imm", 32'(imm), 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        exp_q.delete();
        pend_cnt = 0;
        rst_n = 1'b1;
        apply_ip(4'd0);
        run_start_cyc = cyc + 1;
        n0 = n_commit;
        repeat (80) tick();
        check("post_reset_progress", 32'(n_commit - n0 >= 17), 32'd1);
        finish_run();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
